hardwired_control_unit: RTL and testbench
=========================================

Name: hardwired_control_unit

Overview:
- Moore-style hardwired controller that sequences the bus-based RISC datapath (CPU).
- Generates every per-cycle strobe the datapath exposes: register select, bus-out and bus-in enables, memory, ALU op, HI/LO, I/O port, CON and IncPC.
- Runs fetch T0–T2, decodes IR[31:27], executes T3–T7, then returns to fetch.
- Replaces bench-driven control sequencing; instantiated beside CPU at the top level.

Parameters:
OPW, 5, opcode width (IR[31:27])
ALU_OPW, 5, width of alu_op bus to the ALU

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  synchronous active-high reset
ir  input  32  instruction register contents (held stable T3–T7)
CON  input  1  branch-condition flop output from datapath
run  output  1  high unless in HALT or RESET
illegal_op  output  1  one-cycle pulse on undefined opcode at T3
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select/encode register strobes
R15in  output  1  direct R15 load (jal link)
PCout, PCin, IncPC  output  1 each  PC controls
MARin, MDRin, MDRout, memRead, ramEnable  output  1 each  memory path
Yin, Zin, Zlowout, Zhighout  output  1 each  ALU operand/result registers
HIin, HIout, LOin, LOout  output  1 each  HI/LO registers
IRin, Cout, CONin  output  1 each  IR load, immediate drive, CON latch
InPort_Out, OutPort_In  output  1 each  I/O ports
ADD  output  1  force ALU add (address/branch arithmetic)
alu_op  output  ALU_OPW  ALU function = ir[31:27] when Zin asserted for an ALU class, else 0

Behaviour:
- States: RESET, T0..T7, HALT. Single state register; all outputs decoded combinationally from state, ir[31:27] and CON only.
- clear sampled at rising edge -> state=RESET next cycle, regardless of current state (aborts mid-instruction). In RESET all outputs 0, run=0; next edge -> T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, memRead, MDRin.
  - T2: MDRout, IRin.
- Opcodes:
  - 0 ld; 1 ldi; 2 st.
  - 3–11 ALU R-type (add, sub, and, or, ror, rol, shr, shra, shl).
  - 12–14 addi/andi/ori.
  - 15 div; 16 mul; 17 neg; 18 not.
  - 19 br; 20 jr; 21 jal; 22 in; 23 out.
  - 24 mfhi; 25 mflo; 26 nop; 27 halt.
  - 28–31 illegal.
- Execute sequences (last listed step -> T0 next cycle):
  - ALU R: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op; T5 Zlowout Gra Rin.
  - ALU I: T3 Grb Rout Yin; T4 Cout Zin alu_op; T5 Zlowout Gra Rin.
  - ld/ldi: T3 Grb BAout Yin; T4 Cout ADD Zin.
    - ldi: T5 Zlowout Gra Rin.
    - ld: T5 Zlowout MARin; T6 memRead MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin; T7 MDRout ramEnable.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin alu_op; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 Grb Rout Zin alu_op; T4 Zlowout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 PCin Zlowout only if CON=1, else all zero. Both outcomes -> T0.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout R15in; T4 Gra Rout PCin.
  - in: T3 InPort_Out Gra Rin.
  - out: T3 Gra Rout OutPort_In.
  - mfhi: T3 HIout Gra Rin.
  - mflo: T3 LOout Gra Rin.
  - nop: T3 no strobes.
  - halt: T3 -> HALT; HALT holds all outputs 0, run=0, exits only via clear.
  - illegal: T3 illegal_op=1, no other strobes, -> T0 (treated as nop).
- Invariant: at most one bus driver (Rout, BAout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout, InPort_Out) high in any state; bench asserts this every cycle.
- Latency: fetch 3 cycles; instruction total = 3 + execute steps (e.g. mfhi 4, ld 8, br 7).

Test Plan:
- clear=1 for 1 edge during ld T6 -> next cycle RESET with all outputs 0, run=0; cycle after, T0 with PCout=MARin=IncPC=Zin=1.
- ir=32'hC3000000 (mfhi, ra=R6), datapath HI=32'h0000FFFF -> T3 shows HIout=Gra=Rin=1; R6=32'h0000FFFF after; back to T0 in 4 total cycles.
- ir=32'h19A80000 (add R3,R5,R0) -> T4 alu_op=5'd3 with Grc Rout Zin; T5 Zlowout Gra Rin; 6-cycle instruction.
- br with CON=0 then CON=1 -> T6 PCin=0 vs PCin=Zlowout=1; both return to T0 after T6.
- mul (opcode 16) -> T5 LOin, T6 HIin with Zhighout; no Rin in T3–T6.
- ir opcode 27 -> run falls after T3 and stays 0 for 20 cycles; opcode 30 -> illegal_op pulse exactly 1 cycle, then fetch resumes.

Source files
------------

// File: rtl/hardwired_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hardwired_control_unit
// Description : Moore-style hardwired controller for the bus-based RISC
//               datapath. Fetches in T0-T2, decodes ir[31:27] and executes
//               in T3-T7, producing every per-cycle datapath strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module hardwired_control_unit #(
    parameter int OPW     = 5,
    parameter int ALU_OPW = 5
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [31:0]        ir,
    input  logic               CON,
    output logic               run,
    output logic               illegal_op,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               BAout,
    output logic               R15in,
    output logic               PCout,
    output logic               PCin,
    output logic               IncPC,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               memRead,
    output logic               ramEnable,
    output logic               Yin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               HIin,
    output logic               HIout,
    output logic               LOin,
    output logic               LOout,
    output logic               IRin,
    output logic               Cout,
    output logic               CONin,
    output logic               InPort_Out,
    output logic               OutPort_In,
    output logic               ADD,
    output logic [ALU_OPW-1:0] alu_op
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [OPW-1:0] c_op_ld   = OPW'(0);
    localparam logic [OPW-1:0] c_op_ldi  = OPW'(1);
    localparam logic [OPW-1:0] c_op_st   = OPW'(2);
    localparam logic [OPW-1:0] c_op_add  = OPW'(3);
    localparam logic [OPW-1:0] c_op_shl  = OPW'(11);
    localparam logic [OPW-1:0] c_op_addi = OPW'(12);
    localparam logic [OPW-1:0] c_op_ori  = OPW'(14);
    localparam logic [OPW-1:0] c_op_div  = OPW'(15);
    localparam logic [OPW-1:0] c_op_mul  = OPW'(16);
    localparam logic [OPW-1:0] c_op_neg  = OPW'(17);
    localparam logic [OPW-1:0] c_op_not  = OPW'(18);
    localparam logic [OPW-1:0] c_op_br   = OPW'(19);
    localparam logic [OPW-1:0] c_op_jr   = OPW'(20);
    localparam logic [OPW-1:0] c_op_jal  = OPW'(21);
    localparam logic [OPW-1:0] c_op_in   = OPW'(22);
    localparam logic [OPW-1:0] c_op_out  = OPW'(23);
    localparam logic [OPW-1:0] c_op_mfhi = OPW'(24);
    localparam logic [OPW-1:0] c_op_mflo = OPW'(25);
    localparam logic [OPW-1:0] c_op_halt = OPW'(27);

    state_t         r_state;
    state_t         w_next_state;
    state_t         w_last_step;
    logic [OPW-1:0] w_opcode;
    logic           w_alu_r;
    logic           w_alu_i;
    logic           w_muldiv;
    logic           w_negnot;
    logic           w_alu_class;
    logic           w_illegal;
    logic           w_unused_ir_bits;

    assign w_opcode         = ir[31:32-OPW];
    assign w_unused_ir_bits = ^ir[31-OPW:0];

    // Opcode class decode
    assign w_alu_r     = (w_opcode >= c_op_add)  && (w_opcode <= c_op_shl);
    assign w_alu_i     = (w_opcode >= c_op_addi) && (w_opcode <= c_op_ori);
    assign w_muldiv    = (w_opcode == c_op_div)  || (w_opcode == c_op_mul);
    assign w_negnot    = (w_opcode == c_op_neg)  || (w_opcode == c_op_not);
    assign w_alu_class = w_alu_r || w_alu_i || w_muldiv || w_negnot;
    assign w_illegal   = (w_opcode > c_op_halt);

    // State register; clear aborts any instruction in flight
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Final execute step per opcode; reaching it returns to fetch
    always_comb begin
        w_last_step = S_T3;
        if (w_opcode == c_op_ld || w_opcode == c_op_st) begin
            w_last_step = S_T7;
        end else if (w_opcode == c_op_ldi || w_alu_r || w_alu_i) begin
            w_last_step = S_T5;
        end else if (w_muldiv || w_opcode == c_op_br) begin
            w_last_step = S_T6;
        end else if (w_negnot || w_opcode == c_op_jal) begin
            w_last_step = S_T4;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET: w_next_state = S_T0;
            S_T0:    w_next_state = S_T1;
            S_T1:    w_next_state = S_T2;
            S_T2:    w_next_state = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (r_state == S_T3 && w_opcode == c_op_halt) begin
                    w_next_state = S_HALT;
                end else if (r_state == w_last_step || r_state == S_T7) begin
                    w_next_state = S_T0;
                end else begin
                    w_next_state = state_t'(r_state + 4'd1);
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_RESET;
        endcase
    end

    // Moore output decode from state and opcode (CON only for branch T6)
    always_comb begin
        run        = (r_state != S_RESET) && (r_state != S_HALT);
        illegal_op = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; R15in = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; memRead = 1'b0;
        ramEnable = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
        IRin = 1'b0; Cout = 1'b0; CONin = 1'b0;
        InPort_Out = 1'b0; OutPort_In = 1'b0; ADD = 1'b0;
        alu_op = '0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; memRead = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (w_alu_r || w_alu_i) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_opcode <= c_op_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (w_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end else if (w_opcode == c_op_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (w_opcode == c_op_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (w_opcode == c_op_jal) begin
                    PCout = 1'b1; R15in = 1'b1;
                end else if (w_opcode == c_op_in) begin
                    InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_opcode == c_op_out) begin
                    Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1;
                end else if (w_opcode == c_op_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_opcode == c_op_mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_illegal) begin
                    illegal_op = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu_r) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end else if (w_alu_i) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else if (w_opcode <= c_op_st) begin
                    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                end else if (w_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end else if (w_negnot) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_opcode == c_op_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (w_opcode == c_op_jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            S_T5: begin
                if (w_alu_r || w_alu_i || w_opcode == c_op_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_opcode == c_op_ld || w_opcode == c_op_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (w_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (w_opcode == c_op_br) begin
                    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                end
            end
            S_T6: begin
                if (w_opcode == c_op_ld) begin
                    memRead = 1'b1; MDRin = 1'b1;
                end else if (w_opcode == c_op_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (w_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (w_opcode == c_op_br && CON) begin
                    PCin = 1'b1; Zlowout = 1'b1;
                end
            end
            S_T7: begin
                if (w_opcode == c_op_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_opcode == c_op_st) begin
                    MDRout = 1'b1; ramEnable = 1'b1;
                end
            end
            default: begin
            end
        endcase
        // ALU function only accompanies Zin for ALU-class instructions
        if (Zin && w_alu_class && r_state != S_T0) begin
            alu_op = ALU_OPW'(w_opcode);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hardwired_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hardwired_control_unit
// Description : Table-driven self-checking bench for hardwired_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hardwired_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        CON;
    logic        run, illegal_op, Gra, Grb, Grc, Rin, Rout, BAout, R15in;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead, ramEnable;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
    logic        IRin, Cout, CONin, InPort_Out, OutPort_In, ADD;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    hardwired_control_unit #(.OPW(5), .ALU_OPW(5)) dut (
        .clock(clock), .clear(clear), .ir(ir), .CON(CON), .run(run),
        .illegal_op(illegal_op), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .R15in(R15in), .PCout(PCout), .PCin(PCin),
        .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .memRead(memRead), .ramEnable(ramEnable), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .IRin(IRin), .Cout(Cout), .CONin(CONin),
        .InPort_Out(InPort_Out), .OutPort_In(OutPort_In), .ADD(ADD),
        .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    localparam logic [35:0] GRA = 36'd1 << 0,  GRB = 36'd1 << 1,  GRC = 36'd1 << 2;
    localparam logic [35:0] RIN = 36'd1 << 3,  ROUT = 36'd1 << 4, BAOUT = 36'd1 << 5;
    localparam logic [35:0] R15IN = 36'd1 << 6, PCOUT = 36'd1 << 7, PCIN = 36'd1 << 8;
    localparam logic [35:0] INCPC = 36'd1 << 9, MARIN = 36'd1 << 10, MDRIN = 36'd1 << 11;
    localparam logic [35:0] MDROUT = 36'd1 << 12, MEMREAD = 36'd1 << 13, RAMEN = 36'd1 << 14;
    localparam logic [35:0] YIN = 36'd1 << 15, ZIN = 36'd1 << 16, ZLOWOUT = 36'd1 << 17;
    localparam logic [35:0] ZHIGHOUT = 36'd1 << 18, HIIN = 36'd1 << 19, HIOUT = 36'd1 << 20;
    localparam logic [35:0] LOIN = 36'd1 << 21, LOOUT = 36'd1 << 22, IRIN = 36'd1 << 23;
    localparam logic [35:0] COUT = 36'd1 << 24, CONIN = 36'd1 << 25, INPOUT = 36'd1 << 26;
    localparam logic [35:0] OUTPIN = 36'd1 << 27, ADDS = 36'd1 << 28, ILLEGAL = 36'd1 << 29;
    localparam logic [35:0] RUN = 36'd1 << 30;

    localparam logic [35:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [35:0] F1 = ZLOWOUT | PCIN | MEMREAD | MDRIN;
    localparam logic [35:0] F2 = MDROUT | IRIN;

    logic [35:0] obs;
    always_comb begin
        obs = {alu_op, 31'd0};
        obs[0] = Gra;   obs[1] = Grb;   obs[2] = Grc;   obs[3] = Rin;
        obs[4] = Rout;  obs[5] = BAout; obs[6] = R15in; obs[7] = PCout;
        obs[8] = PCin;  obs[9] = IncPC; obs[10] = MARin; obs[11] = MDRin;
        obs[12] = MDRout; obs[13] = memRead; obs[14] = ramEnable; obs[15] = Yin;
        obs[16] = Zin;  obs[17] = Zlowout; obs[18] = Zhighout; obs[19] = HIin;
        obs[20] = HIout; obs[21] = LOin; obs[22] = LOout; obs[23] = IRin;
        obs[24] = Cout; obs[25] = CONin; obs[26] = InPort_Out; obs[27] = OutPort_In;
        obs[28] = ADD;  obs[29] = illegal_op; obs[30] = run;
    end

    function automatic logic [35:0] alu(input int op);
        return 36'(op) << 31;
    endfunction

    typedef struct {
        string            name;
        logic [31:0]      ir;
        logic             con;
        int               n_exec;
        logic [4:0][35:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic set_vec(input int idx, input string name, input logic [31:0] v_ir,
                           input logic v_con, input int n,
                           input logic [35:0] e3, input logic [35:0] e4,
                           input logic [35:0] e5, input logic [35:0] e6,
                           input logic [35:0] e7);
        tbl[idx].name   = name;
        tbl[idx].ir     = v_ir;
        tbl[idx].con    = v_con;
        tbl[idx].n_exec = n;
        tbl[idx].exp[0] = e3;
        tbl[idx].exp[1] = e4;
        tbl[idx].exp[2] = e5;
        tbl[idx].exp[3] = e6;
        tbl[idx].exp[4] = e7;
    endtask

    task automatic check(input string name, input logic [35:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic reset_to_t0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("reset_state", 36'd0);
        step();
    endtask

    // At most one bus driver in any cycle
    always @(negedge clock) begin
        int drivers;
        drivers = int'(Rout) + int'(BAout) + int'(PCout) + int'(MDRout) + int'(Zlowout)
                + int'(Zhighout) + int'(HIout) + int'(LOout) + int'(Cout) + int'(InPort_Out);
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("FAIL bus_drivers: got %0d expected <=1 at %0t", drivers, $time);
        end
    end

    initial begin
        clear = 1'b1;
        ir    = 32'h0;
        CON   = 1'b0;

        set_vec(0,  "mfhi", 32'hC3000000, 1'b0, 1, HIOUT|GRA|RIN, 0, 0, 0, 0);
        set_vec(1,  "add",  32'h19A80000, 1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZIN|alu(3),
                ZLOWOUT|GRA|RIN, 0, 0);
        set_vec(2,  "addi", 32'h60000000, 1'b0, 3, GRB|ROUT|YIN, COUT|ZIN|alu(12),
                ZLOWOUT|GRA|RIN, 0, 0);
        set_vec(3,  "ld",   32'h00000000, 1'b0, 5, GRB|BAOUT|YIN, COUT|ADDS|ZIN,
                ZLOWOUT|MARIN, MEMREAD|MDRIN, MDROUT|GRA|RIN);
        set_vec(4,  "ldi",  32'h08000000, 1'b0, 3, GRB|BAOUT|YIN, COUT|ADDS|ZIN,
                ZLOWOUT|GRA|RIN, 0, 0);
        set_vec(5,  "st",   32'h10000000, 1'b0, 5, GRB|BAOUT|YIN, COUT|ADDS|ZIN,
                ZLOWOUT|MARIN, GRA|ROUT|MDRIN, MDROUT|RAMEN);
        set_vec(6,  "mul",  32'h80000000, 1'b0, 4, GRA|ROUT|YIN, GRB|ROUT|ZIN|alu(16),
                ZLOWOUT|LOIN, ZHIGHOUT|HIIN, 0);
        set_vec(7,  "div",  32'h78000000, 1'b0, 4, GRA|ROUT|YIN, GRB|ROUT|ZIN|alu(15),
                ZLOWOUT|LOIN, ZHIGHOUT|HIIN, 0);
        set_vec(8,  "neg",  32'h88000000, 1'b0, 2, GRB|ROUT|ZIN|alu(17), ZLOWOUT|GRA|RIN,
                0, 0, 0);
        set_vec(9,  "br0",  32'h98000000, 1'b0, 4, GRA|ROUT|CONIN, PCOUT|YIN,
                COUT|ADDS|ZIN, 0, 0);
        set_vec(10, "br1",  32'h98000000, 1'b1, 4, GRA|ROUT|CONIN, PCOUT|YIN,
                COUT|ADDS|ZIN, PCIN|ZLOWOUT, 0);
        set_vec(11, "jr",   32'hA0000000, 1'b0, 1, GRA|ROUT|PCIN, 0, 0, 0, 0);
        set_vec(12, "jal",  32'hA8000000, 1'b0, 2, PCOUT|R15IN, GRA|ROUT|PCIN, 0, 0, 0);
        set_vec(13, "in",   32'hB0000000, 1'b0, 1, INPOUT|GRA|RIN, 0, 0, 0, 0);
        set_vec(14, "out",  32'hB8000000, 1'b0, 1, GRA|ROUT|OUTPIN, 0, 0, 0, 0);
        set_vec(15, "mflo", 32'hC8000000, 1'b0, 1, LOOUT|GRA|RIN, 0, 0, 0, 0);
        set_vec(16, "nop",  32'hD0000000, 1'b0, 1, 0, 0, 0, 0, 0);
        set_vec(17, "ill30", 32'hF0000000, 1'b0, 1, ILLEGAL, 0, 0, 0, 0);

        step();
        for (int i = 0; i < 18; i++) begin
            reset_to_t0();
            ir  = tbl[i].ir;
            CON = tbl[i].con;
            check({tbl[i].name, "_T0"}, F0 | RUN);
            step();
            check({tbl[i].name, "_T1"}, F1 | RUN);
            step();
            check({tbl[i].name, "_T2"}, F2 | RUN);
            step();
            for (int c = 0; c < tbl[i].n_exec; c++) begin
                check($sformatf("%s_T%0d", tbl[i].name, c + 3), tbl[i].exp[c] | RUN);
                step();
            end
            check({tbl[i].name, "_return_T0"}, F0 | RUN);
        end

        // clear during ld T6 aborts to RESET, then fetch restarts
        reset_to_t0();
        ir = 32'h00000000;
        for (int c = 0; c < 6; c++) step();
        check("abort_ld_T6", MEMREAD | MDRIN | RUN);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort_reset", 36'd0);
        step();
        check("abort_T0", F0 | RUN);

        // halt: run drops after T3 and stays low until clear
        reset_to_t0();
        ir = 32'hD8000000;
        for (int c = 0; c < 3; c++) step();
        check("halt_T3", RUN);
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("halt_hold_%0d", c), 36'd0);
        end
        reset_to_t0();
        check("halt_exit_T0", F0 | RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
